// File: rtl/aes_pkg.sv
// Shared types, constants and lookup helpers for the iterative AES-128 encryption block.
package aes_pkg;

   localparam int NR_DEF = 10;

   typedef logic [127:0] state_t;
   typedef logic [127:0] key_t;
   typedef logic [31:0]  word_t;
   typedef logic [3:0]   round_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      OUT
   } fsm_t;

   // Forward S-box. The first literal byte (0x63) lands in element 255, so a lookup uses ~x as the index.
   localparam logic [255:0][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Round constant consumed when deriving the key for round r (r = 1..10).
   function automatic logic [7:0] rcon(input round_t r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// AddRoundKey: bitwise XOR of a 128-bit state with a 128-bit subkey.
module aes_add_round_key (
   input  logic [127:0] state,
   input  logic [127:0] rkey,
   output logic [127:0] result
);

   assign result = state ^ rkey;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and its Rcon.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [7:0]   rc,
   output logic [127:0] next_key
);

   word_t w0, w1, w2, w3;
   word_t rot, sub, t;
   word_t n0, n1, n2, n3;

   // Word 0 is the most significant word.
   assign {w0, w1, w2, w3} = key;

   // RotWord moves the top byte of w3 to the bottom.
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .a (rot[8*i +: 8]),
         .y (sub[8*i +: 8])
      );
   end

   assign t  = sub ^ {rc, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// Single AES forward S-box byte substitution (combinational lookup).
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = SBOX_TBL[~a];

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state and round-key registers, applies the
// key additions and drives an external combinational round datapath once per cycle.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = NR_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic [127:0] rf_state_o,
   output logic         rf_last_o,
   input  logic [127:0] rf_state_i,
   output logic [3:0]   round_o,
   output logic [127:0] rkey_o
);

   localparam round_t LAST_ROUND = round_t'(NR);

   fsm_t   fsm;
   state_t state;
   key_t   rkey;
   round_t round;

   logic   idle;
   key_t   ks_in;
   key_t   ks_out;
   logic [7:0] ks_rc;
   state_t ark_a;
   state_t ark_b;
   state_t ark_y;

   assign idle = (fsm == IDLE);

   // On accept the schedule starts from the cipher key; during rounds it steps the key register.
   assign ks_in = idle ? key_in : rkey;
   assign ks_rc = idle ? rcon(4'd1) : rcon(round + 4'd1);

   aes_key_step u_key_step (
      .key      (ks_in),
      .rc       (ks_rc),
      .next_key (ks_out)
   );

   // Initial whitening on accept, otherwise round-datapath output XOR the current round key.
   assign ark_a = idle ? data_in : rf_state_i;
   assign ark_b = idle ? key_in  : rkey;

   aes_add_round_key u_ark (
      .state  (ark_a),
      .rkey   (ark_b),
      .result (ark_y)
   );

   assign rf_state_o = state;
   assign rf_last_o  = (fsm == ROUND) && (round == LAST_ROUND);
   assign round_o    = round;
   assign rkey_o     = rkey;

   // Sequencer FSM with registered state, key, round counter and handshake outputs.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all updates in a cycle see the pre-edge values.
      if (rst) begin
         fsm       <= IDLE;
         state     <= '0;
         rkey      <= '0;
         round     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (start) begin
                  state <= ark_y;
                  rkey  <= ks_out;
                  round <= 4'd1;
                  busy  <= 1'b1;
                  fsm   <= ROUND;
               end
            end
            ROUND: begin
               state <= ark_y;
               if (round == LAST_ROUND) begin
                  data_out  <= ark_y;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  fsm       <= OUT;
               end else begin
                  rkey  <= ks_out;
                  round <= round + 4'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  round     <= '0;
                  rkey      <= '0;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES round datapath attached.
module tb_aes_round_ctrl;

   localparam logic [2047:0] SB_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] RK1_C  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] data_in = '0;
   logic         busy;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] data_out;
   logic [127:0] rf_state_o;
   logic         rf_last_o;
   logic [127:0] rf_state_i;
   logic [3:0]   round_o;
   logic [127:0] rkey_o;

   int checks = 0;
   int errors = 0;

   aes_round_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .data_in    (data_in),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .rf_state_o (rf_state_o),
      .rf_last_o  (rf_last_o),
      .rf_state_i (rf_state_i),
      .round_o    (round_o),
      .rkey_o     (rkey_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [7:0] v);
      logic [10:0] pos;
      pos = 11'(2047 - 8 * int'(v));
      return SB_TBL[pos -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes, ShiftRows and (unless last) MixColumns; byte i is bits [127-8i -: 8], column-major.
   function automatic logic [127:0] rf_model(input logic [127:0] s, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] sh;
      logic [127:0] r;
      sh = s;
      for (int i = 0; i < 16; i++) begin
         b[i] = sb(sh[127:120]);
         sh = sh << 8;
      end
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            t[4*c+rw] = b[4*((c+rw)%4)+rw];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      r = '0;
      for (int i = 0; i < 16; i++) r = {r[119:0], t[i]};
      return r;
   endfunction

   always_comb rf_state_i = rf_model(rf_state_o, rf_last_o);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge with the given key and plaintext; returns one cycle after the accept edge.
   task automatic start_block(input logic [127:0] k, input logic [127:0] p);
      key_in  = k;
      data_in = p;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h exp 0", data_out); end
      checks++; if (rf_state_o !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", rf_state_o); end
      checks++; if (rkey_o !== '0) begin errors++; $display("FAIL reset_rkey got %h exp 0", rkey_o); end
      checks++; if (round_o !== 4'd0) begin errors++; $display("FAIL reset_round got %0d exp 0", round_o); end
      checks++; if (rf_last_o !== 1'b0) begin errors++; $display("FAIL reset_rf_last got %0b exp 0", rf_last_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fips_b();
      int   n, busy_n, last_n;
      logic last_bad;
      out_ready = 1'b1;
      start_block(KEY_B, PT_B);
      checks++; if (rkey_o !== RK1_B) begin errors++; $display("FAIL b_rkey1 got %h exp %h", rkey_o, RK1_B); end
      checks++; if (round_o !== 4'd1) begin errors++; $display("FAIL b_round1 got %0d exp 1", round_o); end
      n = 0; busy_n = 0; last_n = 0; last_bad = 1'b0;
      while (out_valid !== 1'b1 && n < 30) begin
         if (busy === 1'b1) busy_n++;
         if (rf_last_o === 1'b1) begin
            last_n++;
            if (round_o !== 4'd10) last_bad = 1'b1;
         end
         tick();
         n++;
      end
      checks++; if (n != 10) begin errors++; $display("FAIL b_latency got %0d exp 10 cycles after accept", n); end
      checks++; if (busy_n != 10) begin errors++; $display("FAIL b_busy_len got %0d exp 10", busy_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b_busy_at_valid got %0b exp 0", busy); end
      checks++; if (last_n != 1 || last_bad) begin errors++; $display("FAIL b_rf_last got count %0d bad_round %0b exp 1 0", last_n, last_bad); end
      checks++; if (data_out !== CT_B) begin errors++; $display("FAIL b_data_out got %h exp %h", data_out, CT_B); end
      checks++; if (rkey_o !== RK10_B) begin errors++; $display("FAIL b_rkey10 got %h exp %h", rkey_o, RK10_B); end
      checks++; if (rf_last_o !== 1'b0) begin errors++; $display("FAIL b_rf_last_in_out got %0b exp 0", rf_last_o); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b_valid_pulse got %0b exp 0", out_valid); end
      checks++; if (round_o !== 4'd0 || rkey_o !== '0) begin errors++; $display("FAIL b_idle_clear got round %0d rkey %h exp 0 0", round_o, rkey_o); end
   endtask

   task automatic test_fips_c1();
      int n;
      out_ready = 1'b1;
      start_block(KEY_C, PT_C);
      checks++; if (rkey_o !== RK1_C) begin errors++; $display("FAIL c_rkey1 got %h exp %h", rkey_o, RK1_C); end
      wait_valid(n);
      checks++; if (n != 10) begin errors++; $display("FAIL c_latency got %0d exp 10", n); end
      checks++; if (data_out !== CT_C) begin errors++; $display("FAIL c_data_out got %h exp %h", data_out, CT_C); end
      tick();
   endtask

   task automatic test_backpressure();
      int n, seen;
      out_ready = 1'b0;
      start_block(KEY_C, PT_C);
      wait_valid(n);
      checks++; if (n != 10) begin errors++; $display("FAIL bp_latency got %0d exp 10", n); end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            key_in = KEY_B; data_in = PT_B; start = 1'b1;
         end
         tick();
         start = 1'b0;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d] got %0b exp 1", i, out_valid); end
         checks++; if (data_out !== CT_C) begin errors++; $display("FAIL bp_data_hold[%0d] got %h exp %h", i, data_out, CT_C); end
      end
      // start together with out_ready in the OUT cycle must be dropped.
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got valid %0b busy %0b exp 0 0", out_valid, busy); end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (busy !== 1'b0 || out_valid !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL bp_no_second got %0d active cycles exp 0", seen); end
   endtask

   task automatic test_back_to_back();
      int   acc_n, res_n, last_n, gap_bad, data_bad, last_acc;
      logic last_bad, prev_busy;
      key_in = KEY_B; data_in = PT_B; out_ready = 1'b1; start = 1'b1;
      acc_n = 0; res_n = 0; last_n = 0; gap_bad = 0; data_bad = 0; last_acc = 0;
      last_bad = 1'b0; prev_busy = busy;
      for (int i = 1; i <= 54; i++) begin
         tick();
         if (busy === 1'b1 && prev_busy !== 1'b1) begin
            if (acc_n > 0 && i - last_acc != 12) gap_bad++;
            last_acc = i;
            acc_n++;
         end
         prev_busy = busy;
         if (out_valid === 1'b1) begin
            res_n++;
            if (data_out !== CT_B) data_bad++;
         end
         if (rf_last_o === 1'b1) begin
            last_n++;
            if (round_o !== 4'd10) last_bad = 1'b1;
         end
         if (i == 40) start = 1'b0;
      end
      checks++; if (acc_n != 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", acc_n); end
      checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0 (12 cycles)", gap_bad); end
      checks++; if (res_n != 4) begin errors++; $display("FAIL b2b_results got %0d exp 4", res_n); end
      checks++; if (data_bad != 0) begin errors++; $display("FAIL b2b_data got %0d wrong exp 0", data_bad); end
      checks++; if (last_n != 4 || last_bad) begin errors++; $display("FAIL b2b_rf_last got count %0d bad_round %0b exp 4 0", last_n, last_bad); end
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b1;
      start_block(KEY_B, PT_B);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_flags got busy %0b valid %0b exp 0 0", busy, out_valid); end
      checks++; if (rf_state_o !== '0 || data_out !== '0) begin errors++; $display("FAIL rm_data got state %h out %h exp 0 0", rf_state_o, data_out); end
      checks++; if (rkey_o !== '0 || round_o !== 4'd0 || rf_last_o !== 1'b0) begin errors++; $display("FAIL rm_ctrl got rkey %h round %0d last %0b exp 0", rkey_o, round_o, rf_last_o); end
      start_block(KEY_B, PT_B);
      wait_valid(n);
      checks++; if (n != 10) begin errors++; $display("FAIL rm_latency got %0d exp 10", n); end
      checks++; if (data_out !== CT_B) begin errors++; $display("FAIL rm_data_out got %h exp %h", data_out, CT_B); end
      tick();
   endtask

   task automatic test_busy_reject();
      int n, seen;
      out_ready = 1'b1;
      start_block(KEY_B, PT_B);
      tick();
      tick();
      key_in = KEY_C; data_in = PT_C; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(n);
      checks++; if (n != 7) begin errors++; $display("FAIL br_latency got %0d exp 7", n); end
      checks++; if (data_out !== CT_B) begin errors++; $display("FAIL br_data_out got %h exp %h", data_out, CT_B); end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (busy !== 1'b0 || out_valid !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL br_no_second got %0d active cycles exp 0", seen); end
   endtask

   initial begin
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_busy_reject();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
